// File: rtl/fmad_issue_if.sv
// rtl/fmad_issue_if.sv - Handshake and bus bundle for the fmad issue/writeback sequencer
//
// Groups the operand input stream, the fmad operand/result bus, the result
// output stream and the sticky flag controls.
//   slave  : sequencer view (fmad_issue)
//   master : environment view (operand source, fmad pipeline, result sink)
interface fmad_issue_if #(
    parameter int TAGW = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_x;
    logic [31:0]     in_y;
    logic [31:0]     in_z;
    logic [TAGW-1:0] in_tag;

    logic            fmad_req;
    logic [31:0]     fmad_x;
    logic [31:0]     fmad_y;
    logic [31:0]     fmad_z;
    logic [31:0]     fmad_rslt;
    logic [4:0]      fmad_flag;

    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_rslt;
    logic [4:0]      out_flag;
    logic [TAGW-1:0] out_tag;

    logic [4:0]      fflags;
    logic            fflags_clr;
    logic            busy;

    modport slave (
        input  in_valid, in_x, in_y, in_z, in_tag,
        input  fmad_rslt, fmad_flag,
        input  out_ready, fflags_clr,
        output in_ready,
        output fmad_req, fmad_x, fmad_y, fmad_z,
        output out_valid, out_rslt, out_flag, out_tag,
        output fflags, busy
    );

    modport master (
        output in_valid, in_x, in_y, in_z, in_tag,
        output fmad_rslt, fmad_flag,
        output out_ready, fflags_clr,
        input  in_ready,
        input  fmad_req, fmad_x, fmad_y, fmad_z,
        input  out_valid, out_rslt, out_flag, out_tag,
        input  fflags, busy
    );
endinterface

// File: rtl/fmad_issue.sv
// rtl/fmad_issue.sv - Issue/writeback sequencer around the two-cycle-hold fmad pipeline
//
// Ports:
//   clk    : single clock
//   reset  : asynchronous active-high reset (also feeds fmad.reset externally)
//   bus    : fmad_issue_if.slave
//            in_*   operand triple stream (valid/ready) with user tag
//            fmad_* operand drive / result capture for the fmad pipeline
//            out_*  in-order result stream from the output FIFO
//            fflags sticky exception flags, fflags_clr clears them
//            busy   outstanding operation count nonzero
module fmad_issue #(
    parameter int TAGW  = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    fmad_issue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]                  state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [31:0]                 opx_q, opx_d, opy_q, opy_d, opz_q, opz_d;
    logic [TAGW-1:0]             optag_q, optag_d;
    logic [3:0]                  dv_q, dv_d;
    logic [3:0][TAGW-1:0]        dtag_q, dtag_d;
    logic [AW:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0][31:0]      mem_rslt_q, mem_rslt_d;
    logic [DEPTH-1:0][4:0]       mem_flag_q, mem_flag_d;
    logic [DEPTH-1:0][TAGW-1:0]  mem_tag_q, mem_tag_d;
    logic [4:0]                  fflags_q, fflags_d;

    logic in_ready_w;
    logic out_valid_w;
    logic accept;
    logic pop;
    logic capture;

    // Space is reserved at acceptance, so a full counter blocks new work
    // even though the FIFO itself may still be partly empty.
    assign in_ready_w  = (state_q != S_ISSUE) && (cnt_q < CW'(DEPTH));
    assign out_valid_w = (wr_ptr_q != rd_ptr_q);
    assign accept      = bus.in_valid && in_ready_w;
    assign pop         = out_valid_w && bus.out_ready;
    // Stage 3 of the tag line lines up with the cycle fmad presents its result.
    assign capture     = dv_q[3];

    assign bus.in_ready  = in_ready_w;
    assign bus.fmad_req  = (state_q == S_ISSUE);
    assign bus.fmad_x    = opx_q;
    assign bus.fmad_y    = opy_q;
    assign bus.fmad_z    = opz_q;
    assign bus.out_valid = out_valid_w;
    assign bus.out_rslt  = mem_rslt_q[rd_ptr_q[AW-1:0]];
    assign bus.out_flag  = mem_flag_q[rd_ptr_q[AW-1:0]];
    assign bus.out_tag   = mem_tag_q[rd_ptr_q[AW-1:0]];
    assign bus.fflags    = fflags_q;
    assign bus.busy      = (cnt_q != '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        opx_d      = opx_q;
        opy_d      = opy_q;
        opz_d      = opz_q;
        optag_d    = optag_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_rslt_d = mem_rslt_q;
        mem_flag_d = mem_flag_q;
        mem_tag_d  = mem_tag_q;
        fflags_d   = fflags_q;

        case (state_q)
            S_IDLE:  if (accept) state_d = S_ISSUE;
            S_ISSUE: state_d = S_HOLD;
            S_HOLD:  state_d = accept ? S_ISSUE : S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Operands stay put through ISSUE and HOLD, which satisfies the
        // fmad two-cycle hold; they are only replaced on a new accept.
        if (accept) begin
            opx_d   = bus.in_x;
            opy_d   = bus.in_y;
            opz_d   = bus.in_z;
            optag_d = bus.in_tag;
        end

        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        dv_d   = {dv_q[2:0], (state_q == S_ISSUE)};
        dtag_d = {dtag_q[2:0], optag_q};

        if (capture) begin
            mem_rslt_d[wr_ptr_q[AW-1:0]] = bus.fmad_rslt;
            mem_flag_d[wr_ptr_q[AW-1:0]] = bus.fmad_flag;
            mem_tag_d[wr_ptr_q[AW-1:0]]  = dtag_q[3];
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end

        // A clear coinciding with a capture must not lose the new flags.
        if (capture) begin
            fflags_d = bus.fflags_clr ? bus.fmad_flag : (fflags_q | bus.fmad_flag);
        end else if (bus.fflags_clr) begin
            fflags_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            opx_q      <= '0;
            opy_q      <= '0;
            opz_q      <= '0;
            optag_q    <= '0;
            dv_q       <= '0;
            dtag_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_rslt_q <= '0;
            mem_flag_q <= '0;
            mem_tag_q  <= '0;
            fflags_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            opx_q      <= opx_d;
            opy_q      <= opy_d;
            opz_q      <= opz_d;
            optag_q    <= optag_d;
            dv_q       <= dv_d;
            dtag_q     <= dtag_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_rslt_q <= mem_rslt_d;
            mem_flag_q <= mem_flag_d;
            mem_tag_q  <= mem_tag_d;
            fflags_q   <= fflags_d;
        end
    end
endmodule

// File: doc/fmad_issue.md
# fmad_issue

Issue and writeback sequencer wrapped around the single-precision FMA pipeline `fmad`. It accepts operand triples over a valid/ready handshake and drives `fmad` with its fixed two-cycle operand-hold protocol. It tracks in-flight operations with a tag delay line and returns results in order through an output FIFO with backpressure. It also accumulates the sticky IEEE exception flags.

## Interface
- `TAGW`, 4, width of the user tag carried with each operation
- `DEPTH`, 4, output FIFO entries; also the maximum number of outstanding operations (power of two, ≥2)

Ports:
- `clk`  in  1  single clock
- `reset`  in  1  asynchronous, active-high; also wired to `fmad.reset`
- `in_valid`  in  1  operand triple offered
- `in_ready`  out  1  triple accepted when `in_valid & in_ready`
- `in_x`, `in_y`, `in_z`  in  32 each  binary32 operands; result is x*y+z
- `in_tag`  in  TAGW  returned with the result
- `fmad_req`  out  1  to `fmad.req`
- `fmad_x`, `fmad_y`, `fmad_z`  out  32 each  to `fmad` operand inputs
- `fmad_rslt`  in  32  from `fmad.rslt`
- `fmad_flag`  in  5  from `fmad.flag`
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  head popped when `out_valid & out_ready`
- `out_rslt`  out  32  result
- `out_flag`  out  5  per-op flags: [4] invalid, [2] overflow, [1] underflow, [0] inexact
- `out_tag`  out  TAGW  tag
- `fflags`  out  5  sticky OR of all captured `fmad_flag`
- `fflags_clr`  in  1  clears `fflags`
- `busy`  out  1  outstanding count nonzero

## Operation
- `fmad` contract: operands must be stable in the `req` cycle T and in T+1. `fmad_rslt`/`fmad_flag` are valid in cycle T+4 and hold until the next op completes. `fmad` cannot stall.
- Issue FSM with states IDLE, ISSUE, HOLD:
  - IDLE: on accept, latch operands and tag into the operand register; go to ISSUE.
  - ISSUE: `fmad_req`=1; operand register drives `fmad_x/y/z`; go to HOLD.
  - HOLD: `fmad_req`=0; operands held. On accept, go to ISSUE (relatch); otherwise go to IDLE. `fmad_x/y/z` keep their last value in IDLE.
- `in_ready` = (state≠ISSUE) & (outstanding < DEPTH).
- The outstanding counter (0..DEPTH) increments on accept and decrements on output pop. On a simultaneous accept and pop it is unchanged. The counter reserves FIFO space at acceptance, so the FIFO never overflows and a capture is never dropped.
- Tag delay line: 4 stages of {valid, tag}. Stage 0 is loaded in the ISSUE cycle with {1, latched tag}; the line shifts every cycle. When stage 3 is valid (cycle T+4), push {`fmad_rslt`, `fmad_flag`, tag} into the FIFO and OR `fmad_flag` into `fflags`.
- Output FIFO: DEPTH entries, in order, pointer wrap modulo DEPTH. Simultaneous push and pop is allowed when full or empty (capacity is guaranteed by the counter).
- `fflags`: `fflags_clr` in the same cycle as a capture gives `fflags <= fmad_flag` (new bits survive). `fflags_clr` alone gives 0.
- Reset (async, any time): state IDLE; counter, delay line, FIFO pointers, `fflags`, operand register cleared. In-flight `fmad` results are discarded.

## Timing
- Reset values: `in_ready`=1, `fmad_req`=0, `fmad_x/y/z`=0, `out_valid`=0, `out_rslt`=0, `out_flag`=0, `out_tag`=0, `fflags`=0, `busy`=0.
- Accept in cycle A: `fmad_req` in A+1, capture in A+5, `out_valid` first high in A+6 (FIFO was empty).
- Peak throughput: one op per 2 cycles (accept in HOLD).
- `out_*` are driven from FIFO storage at the read pointer. A pop takes effect on the next edge.

## Test plan
- Single op: x=0x3f800000, y=0x40000000, z=0x3f000000 accepted in cycle A -> `fmad_req` in A+1; `out_valid` in A+6 with `out_rslt`=0x40200000, `out_flag`=0, `out_tag`=in_tag; `busy` drops after the pop.
- Streaming: `in_valid` held for 5 ops (tags 0..4), `out_ready`=1 -> accepts at A, A+2, …, A+8; results in tag order, one every 2 cycles; `in_ready` low exactly in ISSUE cycles.
- Backpressure: `out_ready`=0, DEPTH=4, 6 ops offered -> exactly 4 accepted, then `in_ready`=0; FIFO holds 4. Raise `out_ready` -> the 4 drain in order, the remaining 2 are then accepted; none lost or duplicated.
- Invalid: x=0x00000000, y=0x7f800000, z=0x3f800000 -> `out_rslt`=0xffc00000, `out_flag`=0x10, `fflags`=0x10. Pulse `fflags_clr` -> `fflags`=0.
- Overflow with simultaneous clear: x=y=0x7f7fffff, z=0, with `fflags`=0x10 and `fflags_clr` asserted in the capture cycle -> `out_rslt`=0x7f800000, `out_flag`=0x05, `fflags`=0x05.
- Reset mid-flight: assert `reset` two cycles after `fmad_req` -> all outputs immediately return to reset values; no `out_valid` appears for the aborted op; a new op after reset completes normally.
